// File: rtl/synfifo_param_if.sv
// Producer/consumer bundle for synfifo_param: write side, read side, fill flags and sticky errors.
// Handshake: wr_en offers data_in, taken at posedge unless full (a simultaneous accepted read frees a slot); rd_en takes the head word unless empty; refused requests only set the sticky flags.
interface synfifo_param_if #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             clr;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, data_in, rd_en,
        input  data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, data_in, rd_en,
        output data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/synfifo_param.sv
// Parametrised synchronous FIFO with fill level, thresholds, sticky error flags, flush and optional FWFT.
// Occupancy is tracked by an explicit level counter so all DEPTH slots are usable for any DEPTH.
module synfifo_param #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0,
    parameter int LW        = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    synfifo_param_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] ram_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             empty_w, full_w;
    logic             rd_acc, wr_acc;
    logic             wr_drop, rd_drop;

    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == LW'(DEPTH));

    // A write on full is still taken when the same cycle's read frees the head slot.
    assign rd_acc  = bus.rd_en & ~empty_w;
    assign wr_acc  = bus.wr_en & (~full_w | rd_acc);
    assign wr_drop = bus.wr_en & ~wr_acc;
    assign rd_drop = bus.rd_en & empty_w;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q | wr_drop;
        underflow_d = underflow_q | rd_drop;

        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; the level counter decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && !bus.clr && wr_acc) begin
            ram_q[wr_ptr_q] <= bus.data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = empty_w ? '0 : ram_q[rd_ptr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] data_q, data_d;

            always_comb begin
                data_d = data_q;
                if (!bus.clr && rd_acc) begin
                    data_d = ram_q[rd_ptr_q];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign bus.data_out = data_q;
        end
    endgenerate

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (level_q <= LW'(AE_THRESH));
    assign bus.almost_full  = (level_q >= LW'(AF_THRESH));
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_synfifo_param.sv
// Directed bench for synfifo_param: registered-read DEPTH=8, FWFT DEPTH=8 and registered-read DEPTH=5 instances.
module tb_synfifo_param;
  localparam int W = 128;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int n_assert = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] wdata;
  int lvl;

  always #5 clk = ~clk;

  synfifo_param_if #(.WIDTH(W), .DEPTH(8)) bus_a ();
  synfifo_param_if #(.WIDTH(W), .DEPTH(8)) bus_b ();
  synfifo_param_if #(.WIDTH(W), .DEPTH(5)) bus_c ();

  synfifo_param #(.WIDTH(W), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a.slave));
  synfifo_param #(.WIDTH(W), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave));
  synfifo_param #(.WIDTH(W), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) dut_c (
    .clk(clk), .rst(rst_c), .bus(bus_c.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.clr = 0; bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.data_in = '0;
    bus_b.clr = 0; bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.data_in = '0;
    bus_c.clr = 0; bus_c.wr_en = 0; bus_c.rd_en = 0; bus_c.data_in = '0;
    tick();
    tick();

    // ---------------- A: reset state ----------------
    chk("a_rst_empty", bus_a.empty, 1);
    chk("a_rst_full", bus_a.full, 0);
    chk("a_rst_ae", bus_a.almost_empty, 1);
    chk("a_rst_af", bus_a.almost_full, 0);
    chk("a_rst_level", bus_a.level, 0);
    chk("a_rst_dout", bus_a.data_out, 0);
    chk("a_rst_ovf", bus_a.overflow, 0);
    chk("a_rst_udf", bus_a.underflow, 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // ---------------- A: fill 0x01..0x08 ----------------
    for (int i = 1; i <= 8; i++) begin
      bus_a.wr_en = 1; bus_a.data_in = W'(i);
      tick();
      chk($sformatf("a_fill_level_%0d", i), bus_a.level, W'(i));
      chk($sformatf("a_fill_af_%0d", i), bus_a.almost_full, (i >= 6) ? 1 : 0);
      chk($sformatf("a_fill_full_%0d", i), bus_a.full, (i == 8) ? 1 : 0);
    end
    bus_a.wr_en = 0;
    chk("a_fill_ovf", bus_a.overflow, 0);

    // ---------------- A: overflow on full ----------------
    bus_a.wr_en = 1; bus_a.data_in = W'('hFF);
    tick();
    bus_a.wr_en = 0;
    chk("a_ovf_flag", bus_a.overflow, 1);
    chk("a_ovf_level", bus_a.level, 8);
    chk("a_ovf_full", bus_a.full, 1);

    // ---------------- A: drain, contents unchanged by dropped write ----------------
    for (int i = 1; i <= 8; i++) begin
      bus_a.rd_en = 1;
      tick();
      chk($sformatf("a_drain_dout_%0d", i), bus_a.data_out, W'(i));
      chk($sformatf("a_drain_level_%0d", i), bus_a.level, W'(8 - i));
      chk($sformatf("a_drain_ae_%0d", i), bus_a.almost_empty, ((8 - i) <= 1) ? 1 : 0);
    end
    chk("a_drain_empty", bus_a.empty, 1);
    chk("a_ovf_sticky", bus_a.overflow, 1);
    tick();
    chk("a_udf_flag", bus_a.underflow, 1);
    chk("a_udf_dout_hold", bus_a.data_out, W'('h08));
    chk("a_udf_level", bus_a.level, 0);
    bus_a.rd_en = 0;

    // ---------------- A: clr ----------------
    bus_a.clr = 1;
    tick();
    bus_a.clr = 0;
    chk("a_clr_level", bus_a.level, 0);
    chk("a_clr_empty", bus_a.empty, 1);
    chk("a_clr_ovf", bus_a.overflow, 0);
    chk("a_clr_udf", bus_a.underflow, 0);
    chk("a_clr_dout_hold", bus_a.data_out, W'('h08));

    // ---------------- A: simultaneous rd+wr on full, pointer wrap ----------------
    for (int i = 1; i <= 8; i++) begin
      bus_a.wr_en = 1; bus_a.data_in = W'(i);
      tick();
    end
    chk("a_sim_pre_full", bus_a.full, 1);
    bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.data_in = W'('h09);
    tick();
    bus_a.wr_en = 0;
    chk("a_sim_level", bus_a.level, 8);
    chk("a_sim_ovf", bus_a.overflow, 0);
    chk("a_sim_dout", bus_a.data_out, W'('h01));
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk($sformatf("a_wrap_dout_%0d", i), bus_a.data_out, W'(i));
    end
    bus_a.rd_en = 0;
    chk("a_wrap_empty", bus_a.empty, 1);

    // ---------------- A: write + read into empty is a write only ----------------
    bus_a.wr_en = 1; bus_a.rd_en = 1; bus_a.data_in = W'('h33);
    tick();
    bus_a.wr_en = 0; bus_a.rd_en = 0;
    chk("a_wre_level", bus_a.level, 1);
    chk("a_wre_udf", bus_a.underflow, 1);
    chk("a_wre_dout_hold", bus_a.data_out, W'('h09));

    // ---------------- B: first-word-fall-through ----------------
    chk("b_rst_dout", bus_b.data_out, 0);
    chk("b_rst_empty", bus_b.empty, 1);
    bus_b.wr_en = 1; bus_b.data_in = W'('hAA);
    tick();
    bus_b.wr_en = 0;
    chk("b_fwft_dout", bus_b.data_out, W'('hAA));
    chk("b_fwft_empty", bus_b.empty, 0);
    tick();
    chk("b_fwft_hold", bus_b.data_out, W'('hAA));
    bus_b.wr_en = 1; bus_b.data_in = W'('hBB);
    tick();
    bus_b.wr_en = 0;
    chk("b_fwft_head", bus_b.data_out, W'('hAA));
    chk("b_fwft_level2", bus_b.level, 2);
    bus_b.rd_en = 1;
    tick();
    chk("b_pop1_dout", bus_b.data_out, W'('hBB));
    chk("b_pop1_level", bus_b.level, 1);
    tick();
    bus_b.rd_en = 0;
    chk("b_pop2_empty", bus_b.empty, 1);
    chk("b_pop2_dout", bus_b.data_out, 0);
    chk("b_pop2_udf", bus_b.underflow, 0);

    // ---------------- C: DEPTH=5 streaming against scoreboard ----------------
    lvl = 0;
    for (int k = 0; k < 14; k++) begin
      bus_c.wr_en = (k < 12);
      bus_c.rd_en = (k >= 2);
      wdata = W'('h1000 + k * 'h11);
      bus_c.data_in = wdata;
      if (k < 12) begin
        exp_q.push_back(wdata);
        lvl++;
      end
      if (k >= 2) lvl--;
      tick();
      if (k >= 2) begin
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        else exp_v = 'x;
        chk($sformatf("c_stream_dout_%0d", k), bus_c.data_out, exp_v);
      end
      chk($sformatf("c_stream_level_%0d", k), bus_c.level, W'(lvl));
    end
    bus_c.wr_en = 0; bus_c.rd_en = 0;
    chk("c_stream_empty", bus_c.empty, 1);
    chk("c_stream_qsize", W'(exp_q.size()), 0);

    // ---------------- C: fill to DEPTH=5, overflow, drain ----------------
    for (int i = 0; i < 5; i++) begin
      wdata = W'('h500 + i);
      bus_c.wr_en = 1; bus_c.data_in = wdata;
      exp_q.push_back(wdata);
      tick();
    end
    chk("c_full", bus_c.full, 1);
    chk("c_full_level", bus_c.level, 5);
    chk("c_full_af", bus_c.almost_full, 1);
    bus_c.data_in = W'('hDEAD);
    tick();
    bus_c.wr_en = 0;
    chk("c_ovf_flag", bus_c.overflow, 1);
    chk("c_ovf_level", bus_c.level, 5);
    bus_c.rd_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (exp_q.size() > 0) exp_v = exp_q.pop_front();
      else exp_v = 'x;
      chk($sformatf("c_drain_dout_%0d", i), bus_c.data_out, exp_v);
    end
    bus_c.rd_en = 0;
    chk("c_drain_empty", bus_c.empty, 1);

    // ---------------- C: reset mid-stream ----------------
    bus_c.wr_en = 1; bus_c.data_in = W'('h77);
    tick();
    bus_c.data_in = W'('h78);
    tick();
    bus_c.wr_en = 0; bus_c.rd_en = 1;
    tick();
    chk("c_mid_dout", bus_c.data_out, W'('h77));
    bus_c.wr_en = 1; bus_c.rd_en = 1; bus_c.data_in = W'('h79);
    rst_c = 1'b0;
    tick();
    chk("c_mrst_empty", bus_c.empty, 1);
    chk("c_mrst_full", bus_c.full, 0);
    chk("c_mrst_ae", bus_c.almost_empty, 1);
    chk("c_mrst_af", bus_c.almost_full, 0);
    chk("c_mrst_level", bus_c.level, 0);
    chk("c_mrst_dout", bus_c.data_out, 0);
    chk("c_mrst_ovf", bus_c.overflow, 0);
    chk("c_mrst_udf", bus_c.underflow, 0);
    rst_c = 1'b1;
    bus_c.wr_en = 1; bus_c.rd_en = 0; bus_c.data_in = W'('h99);
    tick();
    bus_c.wr_en = 0; bus_c.rd_en = 1;
    tick();
    bus_c.rd_en = 0;
    chk("c_post_rst_dout", bus_c.data_out, W'('h99));
    chk("c_post_rst_empty", bus_c.empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
